// File: rtl/txn_timeout_tracker.sv
// Multi-channel transaction watchdog: tracks outstanding IDs per virtual channel,
// flags timeouts, duplicate starts and orphan completions into an error FIFO.
module txn_timeout_tracker #(
  parameter int NUM_CH    = 4,
  parameter int DEPTH     = 16,
  parameter int ID_W      = 12,
  parameter int ADDR_W    = 48,
  parameter int TIMER_W   = 16,
  parameter int LOG_DEPTH = 8,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int OUT_W    = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_valid,
  output logic                        start_ready,
  input  logic [ID_W-1:0]             start_id,
  input  logic [CH_W-1:0]             start_ch,
  input  logic [ADDR_W-1:0]           start_addr,
  input  logic                        cpl_valid,
  input  logic [ID_W-1:0]             cpl_id,
  input  logic [NUM_CH*TIMER_W-1:0]   timeout_limit,
  output logic                        err_valid,
  input  logic                        err_ready,
  output logic [7:0]                  err_code,
  output logic [ID_W-1:0]             err_id,
  output logic [CH_W-1:0]             err_ch,
  output logic [ADDR_W-1:0]           err_addr,
  output logic                        err_overflow,
  input  logic                        err_clear,
  output logic [7:0]                  drop_cnt,
  output logic [OUT_W-1:0]            outstanding
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W = $clog2(LOG_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [7:0] CODE_TIMEOUT = 8'h02;
  localparam logic [7:0] CODE_DUP     = 8'h06;
  localparam logic [7:0] CODE_ORPHAN  = 8'h07;
  localparam logic [TIMER_W-1:0] TIMER_MAX = {TIMER_W{1'b1}};

  logic [DEPTH-1:0]   valid_r;
  logic [ID_W-1:0]    id_r    [DEPTH];
  logic [CH_W-1:0]    ch_r    [DEPTH];
  logic [ADDR_W-1:0]  addr_r  [DEPTH];
  logic [TIMER_W-1:0] timer_r [DEPTH];
  logic [OUT_W-1:0]   outstanding_r;

  logic [TIMER_W-1:0] limit_s [DEPTH];
  logic [DEPTH-1:0]   cpl_hit_s;
  logic [DEPTH-1:0]   dup_hit_s;
  logic [DEPTH-1:0]   cand_s;
  logic [IDX_W-1:0]   free_idx_s;
  logic [IDX_W-1:0]   to_idx_s;
  logic               to_any_s;

  logic               start_fire_s;
  logic               orphan_s;
  logic               dup_s;
  logic               alloc_s;
  logic               to_win_s;
  logic               push_s;
  logic [7:0]         rec_code_s;
  logic [ID_W-1:0]    rec_id_s;
  logic [CH_W-1:0]    rec_ch_s;
  logic [ADDR_W-1:0]  rec_addr_s;

  logic [7:0]         code_mem_r [LOG_DEPTH];
  logic [ID_W-1:0]    id_mem_r   [LOG_DEPTH];
  logic [CH_W-1:0]    ch_mem_r   [LOG_DEPTH];
  logic [ADDR_W-1:0]  addr_mem_r [LOG_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               fifo_full_s;
  logic               wr_en_s;
  logic               pop_s;
  logic [1:0]         drop_inc_s;
  logic [8:0]         drop_sum_s;
  logic [7:0]         drop_cnt_r;
  logic               overflow_r;

  // Per-entry ID matches and timeout candidacy; a completing entry never times out
  always_comb begin
    cpl_hit_s = '0;
    dup_hit_s = '0;
    cand_s    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      limit_s[i]   = timeout_limit[ch_r[i]*TIMER_W +: TIMER_W];
      cpl_hit_s[i] = cpl_valid && valid_r[i] && (id_r[i] == cpl_id);
      dup_hit_s[i] = valid_r[i] && (id_r[i] == start_id) && !cpl_hit_s[i];
      cand_s[i]    = valid_r[i] && !cpl_hit_s[i] && (limit_s[i] != '0) &&
                     (timer_r[i] >= limit_s[i]);
    end
  end

  // Lowest-index free entry and lowest-index timeout candidate
  always_comb begin
    free_idx_s = '0;
    to_idx_s   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      free_idx_s = valid_r[i] ? free_idx_s : IDX_W'(i);
      to_idx_s   = cand_s[i] ? IDX_W'(i) : to_idx_s;
    end
    to_any_s = |cand_s;
  end

  assign start_ready = ~&valid_r;

  // Event arbitration (orphan > duplicate > timeout) and FIFO/drop bookkeeping
  always_comb begin
    start_fire_s = start_valid && start_ready;
    orphan_s     = cpl_valid && (cpl_hit_s == '0);
    dup_s        = start_fire_s && (dup_hit_s != '0);
    alloc_s      = start_fire_s && (dup_hit_s == '0);
    to_win_s     = to_any_s && !orphan_s && !dup_s;
    push_s       = orphan_s || dup_s || to_win_s;
    rec_code_s   = 8'h00;
    rec_id_s     = '0;
    rec_ch_s     = '0;
    rec_addr_s   = '0;
    if (orphan_s) begin
      rec_code_s = CODE_ORPHAN;
      rec_id_s   = cpl_id;
    end else if (dup_s) begin
      rec_code_s = CODE_DUP;
      rec_id_s   = start_id;
      rec_ch_s   = start_ch;
      rec_addr_s = start_addr;
    end else if (to_win_s) begin
      rec_code_s = CODE_TIMEOUT;
      rec_id_s   = id_r[to_idx_s];
      rec_ch_s   = ch_r[to_idx_s];
      rec_addr_s = addr_r[to_idx_s];
    end else begin
      rec_code_s = 8'h00;
    end
    fifo_full_s = (cnt_r == CNT_W'(LOG_DEPTH));
    wr_en_s     = push_s && !fifo_full_s;
    pop_s       = (cnt_r != '0) && err_ready;
    drop_inc_s  = {1'b0, orphan_s && dup_s} + {1'b0, push_s && fifo_full_s};
    drop_sum_s  = {1'b0, (err_clear ? 8'h00 : drop_cnt_r)} + 9'(drop_inc_s);
  end

  // Tracker entry allocation, release and ageing
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r       <= '0;
      outstanding_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        id_r[i]    <= '0;
        ch_r[i]    <= '0;
        addr_r[i]  <= '0;
        timer_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cpl_hit_s[i] || (to_win_s && (to_idx_s == IDX_W'(i)))) begin
          valid_r[i] <= 1'b0;
        end else if (alloc_s && (free_idx_s == IDX_W'(i))) begin
          valid_r[i] <= 1'b1;
          id_r[i]    <= start_id;
          ch_r[i]    <= start_ch;
          addr_r[i]  <= start_addr;
          timer_r[i] <= '0;
        end else if (valid_r[i] && (timer_r[i] != TIMER_MAX)) begin
          timer_r[i] <= timer_r[i] + TIMER_W'(1);
        end
      end
      outstanding_r <= outstanding_r + OUT_W'(alloc_s) - OUT_W'(|cpl_hit_s) - OUT_W'(to_win_s);
    end
  end

  // Error record FIFO; fullness is judged before the same-cycle pop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
      for (int i = 0; i < LOG_DEPTH; i++) begin
        code_mem_r[i] <= 8'h00;
        id_mem_r[i]   <= '0;
        ch_mem_r[i]   <= '0;
        addr_mem_r[i] <= '0;
      end
    end else begin
      if (wr_en_s) begin
        code_mem_r[wr_ptr_r] <= rec_code_s;
        id_mem_r[wr_ptr_r]   <= rec_id_s;
        ch_mem_r[wr_ptr_r]   <= rec_ch_s;
        addr_mem_r[wr_ptr_r] <= rec_addr_s;
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      cnt_r <= cnt_r + CNT_W'(wr_en_s) - CNT_W'(pop_s);
    end
  end

  // Sticky overflow flag and saturating drop counter; a drop beats err_clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= 8'h00;
    end else if (drop_inc_s != 2'd0) begin
      overflow_r <= 1'b1;
      drop_cnt_r <= drop_sum_s[8] ? 8'hFF : drop_sum_s[7:0];
    end else if (err_clear) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= 8'h00;
    end
  end

  assign err_valid    = (cnt_r != '0);
  assign err_code     = code_mem_r[rd_ptr_r];
  assign err_id       = id_mem_r[rd_ptr_r];
  assign err_ch       = ch_mem_r[rd_ptr_r];
  assign err_addr     = addr_mem_r[rd_ptr_r];
  assign err_overflow = overflow_r;
  assign drop_cnt     = drop_cnt_r;
  assign outstanding  = outstanding_r;

endmodule
